lpm_mac_pipe: RTL

- Pipelined, multi-channel multiply-accumulate unit. It is the next generation of the library's LPM multiplier and keeps the same `dataa` / `datab` / `clken` port names.
- Adds the following, which the existing multiplier lacks:
  - per-channel accumulators;
  - runtime signed/unsigned selection;
  - valid/ready handshaking with backpressure;
  - output saturation with a sticky flag.
- Sits in DSP datapaths (FIR taps, dot products, correlators) between a sample source and a downstream consumer.

---
 rtl/lpm_mac_pkg.sv | 67 ++++++
 rtl/lpm_mac_mul_pipe.sv | 66 ++++++
 rtl/lpm_mac_pipe.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/lpm_mac_pkg.sv
// Shared definitions for the lpm_mac_pipe multiply-accumulate unit.
//   wacc_f / chw_f : derived widths (accumulator width, channel index width)
//   mac_ctl_t      : control word that travels alongside each product
//   sat_to_wp      : clamp a pre-extended accumulator value to WP bits
package lpm_mac_pkg;

  // Channel field is stored at a fixed width so the struct is not parameterised;
  // only the low CHW bits are meaningful, but the full field is range-checked.
  localparam int CH_MAX_W = 8;
  // Working width for saturation; must exceed any accumulator width in use.
  localparam int SAT_W = 128;

  function automatic int wacc_f(input int wa, input int wb, input int guard);
    return wa + wb + guard;
  endfunction

  function automatic int chw_f(input int num_ch);
    return (num_ch <= 2) ? 1 : $clog2(num_ch);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [CH_MAX_W-1:0] ch;
    logic                first;
    logic                last;
    logic                sgn;
  } mac_ctl_t;

  localparam int CTL_W = $bits(mac_ctl_t);

  typedef struct packed {
    logic             sat;
    logic [SAT_W-1:0] val;
  } sat_res_t;

  // The caller extends acc to SAT_W (sign- or zero-extension according to sgn),
  // so one compare against the WP-bit limits covers both number systems. When
  // WP equals the accumulator width the value always lies inside the limits.
  function automatic sat_res_t sat_to_wp(input logic [SAT_W-1:0] acc,
                                         input int wp, input logic sgn);
    logic signed [SAT_W-1:0] s_acc;
    logic signed [SAT_W-1:0] s_max;
    logic signed [SAT_W-1:0] s_min;
    logic [SAT_W-1:0]        u_max;
    sat_res_t                r;
    s_acc = acc;
    s_max = $signed((SAT_W'(1) << (wp - 1)) - SAT_W'(1));
    s_min = ~s_max;
    u_max = (SAT_W'(1) << wp) - SAT_W'(1);
    r.sat = 1'b0;
    r.val = acc;
    if (sgn) begin
      if (s_acc > s_max) begin
        r.val = s_max;
        r.sat = 1'b1;
      end else if (s_acc < s_min) begin
        r.val = s_min;
        r.sat = 1'b1;
      end
    end else if (acc > u_max) begin
      r.val = u_max;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/lpm_mac_mul_pipe.sv
// PIPE-stage multiplier with runtime signed/unsigned selection. The control
// word rides alongside the product; only its valid bit is reset.
//   clock, sclr_n : clock and synchronous active-low reset
//   adv           : pipeline advance (all stages shift together)
//   dataa, datab  : operands, interpreted per ctl_in.sgn
//   ctl_in        : packed mac_ctl_t for the beat entering stage 1
//   prod, ctl_out : full-precision product and control leaving stage PIPE
module lpm_mac_mul_pipe
  import lpm_mac_pkg::*;
#(
  parameter int WA   = 16,
  parameter int WB   = 16,
  parameter int PIPE = 2
) (
  input  logic               clock,
  input  logic               sclr_n,
  input  logic               adv,
  input  logic [WA-1:0]      dataa,
  input  logic [WB-1:0]      datab,
  input  logic [CTL_W-1:0]   ctl_in,
  output logic [WA+WB-1:0]   prod,
  output logic [CTL_W-1:0]   ctl_out
);

  localparam int WM = WA + WB;

  mac_ctl_t      w_ctl_in;
  logic [WM-1:0] w_a_ext;
  logic [WM-1:0] w_b_ext;
  logic [WM-1:0] w_prod;

  logic [WM-1:0] r_prod_p [PIPE];
  mac_ctl_t      r_ctl_p  [PIPE];

  assign w_ctl_in = ctl_in;

  // Extending both operands to WM bits and keeping the low WM bits of the
  // product gives the exact signed or unsigned result in one multiplier.
  always_comb begin
    w_a_ext = w_ctl_in.sgn ? {{WB{dataa[WA-1]}}, dataa} : {{WB{1'b0}}, dataa};
    w_b_ext = w_ctl_in.sgn ? {{WA{datab[WB-1]}}, datab} : {{WA{1'b0}}, datab};
    w_prod  = w_a_ext * w_b_ext;
  end

  // ---- stage 1 .. PIPE: control (valid is the only reset field) ----
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      for (int i = 0; i < PIPE; i++) r_ctl_p[i].valid <= 1'b0;
    end else if (adv) begin
      r_ctl_p[0] <= w_ctl_in;
      for (int i = 1; i < PIPE; i++) r_ctl_p[i] <= r_ctl_p[i-1];
    end
  end

  // ---- stage 1 .. PIPE: product data ----
  always_ff @(posedge clock) begin
    if (adv) begin
      r_prod_p[0] <= w_prod;
      for (int i = 1; i < PIPE; i++) r_prod_p[i] <= r_prod_p[i-1];
    end
  end

  assign prod    = r_prod_p[PIPE-1];
  assign ctl_out = r_ctl_p[PIPE-1];

endmodule

// File: rtl/lpm_mac_pipe.sv
// Pipelined multi-channel multiply-accumulate with saturating output and a
// valid/ready handshake. Beats flow: multiplier (PIPE stages) -> accumulate
// (read-modify-write of acc[ch]) -> output register.
//   clock, sclr_n, clken   : clock, sync active-low reset, global enable
//   in_valid / in_ready    : input handshake
//   dataa, datab           : operands
//   in_signed, in_ch       : per-beat number system and target channel
//   in_first, in_last      : load accumulator / emit result after this beat
//   out_valid / out_ready  : output handshake
//   out_ch, result, out_sat: channel, clamped result, clamp indication
//   sat_sticky             : per-channel sticky clamp flags
module lpm_mac_pipe
  import lpm_mac_pkg::*;
#(
  parameter int WA     = 16,
  parameter int WB     = 16,
  parameter int GUARD  = 4,
  parameter int WP     = 32,
  parameter int NUM_CH = 4,
  parameter int PIPE   = 2,
  localparam int WACC  = wacc_f(WA, WB, GUARD),
  localparam int CHW   = chw_f(NUM_CH)
) (
  input  logic              clock,
  input  logic              sclr_n,
  input  logic              clken,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WA-1:0]     dataa,
  input  logic [WB-1:0]     datab,
  input  logic              in_signed,
  input  logic [CHW-1:0]    in_ch,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CHW-1:0]    out_ch,
  output logic [WP-1:0]     result,
  output logic              out_sat,
  output logic [NUM_CH-1:0] sat_sticky
);

  localparam int WM = WA + WB;

  // Extends per number system, then clamps to WP bits; returns {sat, value}.
  function automatic logic [WP:0] sat_wp(input logic [WACC-1:0] acc, input logic sgn);
    sat_res_t         r;
    logic [SAT_W-1:0] ext;
    if (sgn) ext = SAT_W'($signed(acc));
    else     ext = SAT_W'(acc);
    r = sat_to_wp(ext, WP, sgn);
    return {r.sat, r.val[WP-1:0]};
  endfunction

  logic              w_adv;
  logic              w_accept;
  mac_ctl_t          w_ctl_in;
  logic [CTL_W-1:0]  w_ctl_in_bits;
  logic [CTL_W-1:0]  w_ctl_mul_bits;
  mac_ctl_t          w_ctl_a;
  logic [WM-1:0]     w_prod;
  logic              w_ch_ok;
  logic [CHW-1:0]    w_chi;
  logic [WACC-1:0]   w_prod_ext;
  logic [WACC-1:0]   w_acc_old;
  logic [WACC-1:0]   w_acc_next;
  logic [WP:0]       w_sat;

  logic [WACC-1:0]   r_acc [NUM_CH];
  logic [NUM_CH-1:0] r_sticky;
  logic              r_vld_acc;
  logic [CHW-1:0]    r_ch_acc;
  logic [WP-1:0]     r_res_acc;
  logic              r_sat_acc;
  logic              r_out_valid;
  logic [CHW-1:0]    r_out_ch;
  logic [WP-1:0]     r_result;
  logic              r_out_sat;

  // A held output stalls everything, so an unconsumed result is never overwritten.
  assign w_adv    = clken & ~(r_out_valid & ~out_ready);
  assign in_ready = w_adv & sclr_n;
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_ctl_in       = '0;
    w_ctl_in.valid = w_accept;
    w_ctl_in.ch    = CH_MAX_W'(in_ch);
    w_ctl_in.first = in_first;
    w_ctl_in.last  = in_last;
    w_ctl_in.sgn   = in_signed;
  end
  assign w_ctl_in_bits = w_ctl_in;

  lpm_mac_mul_pipe #(
    .WA   (WA),
    .WB   (WB),
    .PIPE (PIPE)
  ) u_mul (
    .clock   (clock),
    .sclr_n  (sclr_n),
    .adv     (w_adv),
    .dataa   (dataa),
    .datab   (datab),
    .ctl_in  (w_ctl_in_bits),
    .prod    (w_prod),
    .ctl_out (w_ctl_mul_bits)
  );

  assign w_ctl_a = w_ctl_mul_bits;

  // ---- accumulate stage: combinational read-modify-write of acc[ch] ----
  // Out-of-range channels still flow but never touch the bank or the output.
  always_comb begin
    w_ch_ok    = (w_ctl_a.ch < CH_MAX_W'(NUM_CH));
    w_chi      = w_ctl_a.ch[CHW-1:0];
    w_prod_ext = w_ctl_a.sgn ? WACC'($signed(w_prod)) : WACC'(w_prod);
    w_acc_old  = w_ch_ok ? r_acc[w_chi] : '0;
    w_acc_next = w_ctl_a.first ? w_prod_ext : (w_acc_old + w_prod_ext);
    w_sat      = sat_wp(w_acc_next, w_ctl_a.sgn);
  end

  // ---- accumulate -> output register boundary (control and bank) ----
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= '0;
      r_sticky    <= '0;
      r_vld_acc   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_result    <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_adv) begin
      if (w_ctl_a.valid && w_ch_ok) begin
        r_acc[w_chi] <= w_acc_next;
        // A run's first beat clears the flag; a clamp on its last beat sets it.
        if (w_ctl_a.first) r_sticky[w_chi] <= 1'b0;
        if (w_ctl_a.last && w_sat[WP]) r_sticky[w_chi] <= 1'b1;
      end
      r_vld_acc <= w_ctl_a.valid & w_ch_ok & w_ctl_a.last;
      if (r_vld_acc) begin
        r_out_valid <= 1'b1;
        r_out_ch    <= r_ch_acc;
        r_result    <= r_res_acc;
        r_out_sat   <= r_sat_acc;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // ---- accumulate -> output register boundary (clamped data) ----
  always_ff @(posedge clock) begin
    if (w_adv) begin
      r_ch_acc  <= w_chi;
      r_res_acc <= w_sat[WP-1:0];
      r_sat_acc <= w_sat[WP];
    end
  end

  assign out_valid  = r_out_valid;
  assign out_ch     = r_out_ch;
  assign result     = r_result;
  assign out_sat    = r_out_sat;
  assign sat_sticky = r_sticky;

endmodule
